// File: rtl/dec_scan_driver_if.sv
// rtl/dec_scan_driver_if.sv - control and decoder-select bundle for dec_scan_driver
// Optional frame_start member present only when DEC_SCAN_FRAME_PULSE_EN is defined.
interface dec_scan_driver_if #(
    parameter int SEL_W = 2
);
    logic                  run;
    logic                  hold;
    logic [2**SEL_W-1:0]   mask;
    logic [SEL_W-1:0]      a;
    logic                  en;
`ifdef DEC_SCAN_FRAME_PULSE_EN
    logic                  frame_start;
`endif

    modport master (
        input  run,
        input  hold,
        input  mask,
`ifdef DEC_SCAN_FRAME_PULSE_EN
        output frame_start,
`endif
        output a,
        output en
    );

    modport slave (
        output run,
        output hold,
        output mask,
`ifdef DEC_SCAN_FRAME_PULSE_EN
        input  frame_start,
`endif
        input  a,
        input  en
    );
endinterface

// File: rtl/dec_scan_driver.sv
// rtl/dec_scan_driver.sv - scans enabled decoder select codes with dwell and blanking gap
// Optional frame_start pulse is built when DEC_SCAN_FRAME_PULSE_EN is defined.
module dec_scan_driver #(
    parameter int SEL_W = 2,
    parameter int DWELL = 1000,
    parameter int BLANK = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dec_scan_driver_if.master bus
);
    localparam int NCODE   = 2**SEL_W;
    localparam int CNT_MAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                             : ((BLANK > 2) ? BLANK : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_a;
    logic             r_en;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [SEL_W-1:0] w_a_nxt;
    logic             w_en_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [SEL_W-1:0] w_low;
    logic [SEL_W-1:0] w_above;
    logic             w_above_found;
    logic [SEL_W-1:0] w_next;
    logic             w_mask_any;
    logic             w_dwell_done;
    logic             w_blank_done;
    logic             w_step;

    // Descending walk so the lowest qualifying index is the last one written.
    always_comb begin
        w_low         = '0;
        w_above       = '0;
        w_above_found = 1'b0;
        for (int i = NCODE - 1; i >= 0; i--) begin
            if (bus.mask[i]) begin
                w_low = SEL_W'(i);
                if (i > int'(r_a)) begin
                    w_above       = SEL_W'(i);
                    w_above_found = 1'b1;
                end
            end
        end
    end

    assign w_next       = w_above_found ? w_above : w_low;
    assign w_mask_any   = |bus.mask;
    assign w_dwell_done = (r_state == S_ACTIVE) && (r_cnt == DWELL_LAST);
    assign w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
    // A new code is chosen at the end of a blank, or straight after a dwell when there is no gap.
    assign w_step       = w_blank_done || (w_dwell_done && (BLANK == 0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_en    <= w_en_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.run) begin
            w_state_nxt = S_IDLE;
        end else if (!bus.hold) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mask_any) w_state_nxt = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_dwell_done) begin
                        if (BLANK > 0)        w_state_nxt = S_BLANK;
                        else if (!w_mask_any) w_state_nxt = S_IDLE;
                    end
                end
                S_BLANK: begin
                    if (w_blank_done) w_state_nxt = w_mask_any ? S_ACTIVE : S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_a_nxt   = r_a;
        w_en_nxt  = r_en;
        w_cnt_nxt = r_cnt;
        if (!bus.run) begin
            w_en_nxt  = 1'b0;
            w_cnt_nxt = '0;
        end else if (!bus.hold) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mask_any) begin
                        w_a_nxt   = w_low;
                        w_en_nxt  = 1'b1;
                        w_cnt_nxt = '0;
                    end
                end
                S_ACTIVE, S_BLANK: begin
                    if (w_dwell_done || w_blank_done) begin
                        w_cnt_nxt = '0;
                        if (w_step && w_mask_any) begin
                            w_a_nxt  = w_next;
                            w_en_nxt = 1'b1;
                        end else begin
                            w_en_nxt = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_en_nxt  = 1'b0;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign bus.a  = r_a;
    assign bus.en = r_en;

`ifdef DEC_SCAN_FRAME_PULSE_EN
    logic r_frame;
    logic w_frame_nxt;

    // A frame begins whenever the lowest set code is (re)entered; hold forces it low.
    always_comb begin
        w_frame_nxt = 1'b0;
        if (bus.run && !bus.hold && w_mask_any) begin
            if (r_state == S_IDLE)               w_frame_nxt = 1'b1;
            else if (w_step && (w_next == w_low)) w_frame_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_frame <= 1'b0;
        else       r_frame <= w_frame_nxt;
    end

    assign bus.frame_start = r_frame;
`endif
endmodule

// File: tb/tb_dec_scan_driver.sv
// tb/tb_dec_scan_driver.sv - self-checking bench for dec_scan_driver (BLANK=2 and BLANK=0 builds)
module tb_dec_scan_driver;
    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       hold;
    logic [3:0] mask;

    always #5 clk = ~clk;

    dec_scan_driver_if #(.SEL_W(2)) bus0 ();
    dec_scan_driver_if #(.SEL_W(2)) bus1 ();

    assign bus0.run  = run;
    assign bus0.hold = hold;
    assign bus0.mask = mask;
    assign bus1.run  = run;
    assign bus1.hold = hold;
    assign bus1.mask = mask;

    dec_scan_driver #(.SEL_W(2), .DWELL(DW), .BLANK(2)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.master)
    );

    dec_scan_driver #(.SEL_W(2), .DWELL(DW), .BLANK(0)) u_dut_b0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: count-down of cycles left in the current lit/dark interval.
    int m_on[2]    = '{0, 0};
    int m_a[2]     = '{0, 0};
    int m_en[2]    = '{0, 0};
    int m_left[2]  = '{0, 0};
    int m_frame[2] = '{0, 0};
    int m_blank[2] = '{2, 0};

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_code(input logic [3:0] m, input int cur);
        for (int i = cur + 1; i < 4; i++) if (m[i]) return i;
        return lowest(m);
    endfunction

    task automatic model_step();
        int n;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_on[k] = 0; m_a[k] = 0; m_en[k] = 0; m_left[k] = 0; m_frame[k] = 0;
            end else if (!run) begin
                m_on[k] = 0; m_en[k] = 0; m_frame[k] = 0;
            end else if (hold) begin
                m_frame[k] = 0;
            end else begin
                m_frame[k] = 0;
                if (m_on[k] == 0) begin
                    if (mask != 4'd0) begin
                        m_on[k] = 1; m_a[k] = lowest(mask); m_en[k] = 1;
                        m_left[k] = DW; m_frame[k] = 1;
                    end
                end else begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        if (m_en[k] == 1 && m_blank[k] > 0) begin
                            m_en[k] = 0; m_left[k] = m_blank[k];
                        end else if (mask == 4'd0) begin
                            m_on[k] = 0; m_en[k] = 0;
                        end else begin
                            n = next_code(mask, m_a[k]);
                            m_frame[k] = (n == lowest(mask)) ? 1 : 0;
                            m_a[k] = n; m_en[k] = 1; m_left[k] = DW;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("a_blank2",  32'(bus0.a),  32'(m_a[0]));
        chk("en_blank2", 32'(bus0.en), 32'(m_en[0]));
        chk("a_blank0",  32'(bus1.a),  32'(m_a[1]));
        chk("en_blank0", 32'(bus1.en), 32'(m_en[1]));
`ifdef DEC_SCAN_FRAME_PULSE_EN
        chk("frame_blank2", 32'(bus0.frame_start), 32'(m_frame[0]));
        chk("frame_blank0", 32'(bus1.frame_start), 32'(m_frame[1]));
`endif
    endtask

    initial begin
        int found;
        rst = 1'b1; run = 1'b1; hold = 1'b0; mask = 4'b1111;

        repeat (3) begin
            cyc();
            chk("rst_a", 32'(bus0.a), 32'd0);
            chk("rst_en", 32'(bus0.en), 32'd0);
        end
        rst = 1'b0;
        cyc();
        chk("start_a", 32'(bus0.a), 32'd0);
        chk("start_en", 32'(bus0.en), 32'd1);
        repeat (30) cyc();

        mask = 4'b1010;
        repeat (30) cyc();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cyc();
            if (bus0.a == 2'd3 && bus0.en) found = 1;
        end
        chk("wait_code3", 32'(found), 32'd1);
        cyc();
        mask = 4'b0100;
        repeat (30) cyc();
        chk("single_a", 32'(bus0.a), 32'd2);

        mask = 4'b1111;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cyc();
            if (bus0.a == 2'd1 && bus0.en) found = 1;
        end
        chk("wait_code1", 32'(found), 32'd1);
        cyc();
        hold = 1'b1;
        repeat (5) cyc();
        hold = 1'b0;
        repeat (12) cyc();

        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cyc();
            if (bus0.a == 2'd2 && !bus0.en) found = 1;
        end
        chk("wait_blank2", 32'(found), 32'd1);
        run = 1'b0;
        repeat (3) begin
            cyc();
            chk("drop_en", 32'(bus0.en), 32'd0);
            chk("drop_a", 32'(bus0.a), 32'd2);
        end
        run = 1'b1;
        cyc();
        chk("restart_a", 32'(bus0.a), 32'd0);
        chk("restart_en", 32'(bus0.en), 32'd1);
        repeat (10) cyc();

        mask = 4'b0000;
        repeat (8) cyc();
        repeat (20) begin
            cyc();
            chk("mask0_en", 32'(bus0.en), 32'd0);
        end

        mask = 4'b1111;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            cyc();
            if (bus0.a == 2'd3 && bus0.en) found = 1;
        end
        chk("wait_code3b", 32'(found), 32'd1);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_a", 32'(bus0.a), 32'd0);
        chk("midrst_en", 32'(bus0.en), 32'd0);
        rst = 1'b0;
        repeat (40) cyc();

        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom % 300) == 0;
            run  = ($urandom % 40) != 0;
            hold = ($urandom % 10) == 0;
            if (($urandom % 16) == 0) mask = 4'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dec_scan_driver.md
Name: dec_scan_driver

Overview:
- Sequential select generator sitting directly upstream of the 2-to-4 (generally N-to-2^N) decoder.
- Drives the decoder's A and en inputs, stepping through all enabled select codes in ascending order with wrap-around.
- Each code is held for a programmable dwell time, followed by an optional blanking gap with en low, so decoder outputs never overlap.
- Typical use: multiplexed display digit scanning, row strobing.

Parameters:
- SEL_W, 2, width of the select code A; decoder has 2**SEL_W outputs.
- DWELL, 1000, clock cycles en is high per code; legal range >= 1.
- BLANK, 10, clock cycles en is low between codes; legal range >= 0 (0 = no gap).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  scan enable; low forces IDLE.
- hold  input  1  freezes the scan (counter, state, outputs).
- mask  input  2**SEL_W  per-code enable; bit i high = code i is scanned.
- A  output  SEL_W  select code to the decoder A input.
- en  output  1  enable to the decoder en input.

Behaviour:
- Clocking and reset: all logic on clk rising edge; the reset is synchronous and active-high.
- Reset values: state=IDLE, A=0, en=0, dwell/blank counter=0.
- All outputs are registered, straight from flops; no combinational input-to-output path.
- Counter width: $clog2 of max(DWELL, BLANK, 2).

States:
- IDLE:
  - en=0; A holds its last value.
  - If run=1 and mask!=0 at an edge: A<=lowest set mask bit index, en<=1, cnt<=0, go ACTIVE.
  - Latency: en and A are valid the cycle after run is first sampled high.
- ACTIVE:
  - en=1; cnt increments each non-hold cycle.
  - At cnt==DWELL-1, with BLANK>0: go BLANK, en<=0, cnt<=0; A unchanged.
  - At cnt==DWELL-1, with BLANK==0: A<=next code, en stays 1, cnt<=0, stay ACTIVE.
- BLANK:
  - en=0; A holds the previous code.
  - At cnt==BLANK-1: A<=next code, en<=1, cnt<=0, go ACTIVE.

Next-code selection:
- Next code = smallest set mask index strictly greater than the current A; if none, wrap to the lowest set index.
- Mask is sampled only at the moment the next code is chosen.
- If the current code is the only set bit, A repeats with the same dwell/blank rhythm.
- If mask==0 when a next code is needed: go IDLE, en<=0, A holds.

Mask and control priority:
- A mask change mid-dwell or mid-blank never shortens the current interval.
- Priority, highest first: rst > run=0 > hold > normal sequencing.
- run=0 in any state: go IDLE at the next edge, en<=0, A holds, cnt<=0.
- hold=1 with run=1: state, cnt, A and en all frozen. In IDLE, hold blocks the start.
- Re-entry from IDLE always restarts at the lowest set mask bit; the scan does not resume mid-sequence.

Boundary conditions:
- DWELL=1 gives a one-cycle strobe per code.
- With SEL_W=2, A wraps 3->0.

Optional Feature:
- Macro: DEC_SCAN_FRAME_PULSE_EN.
- Defined:
  - Adds output port frame_start (1 bit), reset 0.
  - Registered; high for exactly one cycle: the first ACTIVE cycle of the lowest set mask code, both on IDLE exit and on every wrap.
  - Frozen low while hold=1.
  - With a single set mask bit, it pulses at every dwell start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
All scenarios use SEL_W=2, DWELL=4, BLANK=2 unless stated.
1. Reset and full scan:
   - Stimulus: rst=1 for 3 cycles with run=1, mask=4'b1111, then rst=0.
   - Response: during reset A=0, en=0. One cycle after release A=0, en=1 for 4 cycles, then en=0 for 2 cycles. Then A=1,2,3 each with the same pattern, then wrap to A=0.
2. Sparse mask:
   - Stimulus: mask=4'b1010.
   - Response: A sequence 1,3,1,3. Mask changed to 4'b0100 mid-dwell on code 3: code 3 finishes its 4 cycles plus blank, then A=2 repeats indefinitely.
3. Hold:
   - Stimulus: hold=1 for 5 cycles, starting in cycle 2 of a dwell.
   - Response: en stays high for 9 consecutive cycles total; A unchanged; the blank then follows normally.
4. Run drop and mask zero:
   - Stimulus a: run=0 during BLANK on code 2, then run=1 again after 3 cycles.
   - Response a: en=0, A=2 held while run=0; after re-assert, restart at A=0.
   - Stimulus b: run=1 with mask=0.
   - Response b: block stays IDLE, en=0 indefinitely.
5. Reset mid-operation and BLANK=0 variant:
   - Stimulus a: rst=1 in cycle 3 of ACTIVE on code 3.
   - Response a: next cycle A=0, en=0.
   - Stimulus b: rebuild with BLANK=0, mask=4'b1111.
   - Response b: en continuously 1; A changes every 4 cycles 0,1,2,3,0.
6. Feature build (DEC_SCAN_FRAME_PULSE_EN defined):
   - Stimulus: mask=4'b1111.
   - Response: frame_start=1 only in the first A=0 ACTIVE cycle of each frame, once every 24 cycles.
